// File: rtl/uart_framer_pkg.sv
// Shared types and helpers for the UART market-data message framer.
package uart_framer_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CKSUM,
        S_HOLD
    } framer_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic len_ok(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle counter; expire pulses when TIMEOUT_CLKS idle clocks pass inside a frame.
module uart_frame_timer #(
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [CNT_W-1:0] cnt;

    // An arriving byte beats expiry in the same cycle.
    assign expire = enable && !clear && (cnt == CNT_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_msg_framer.sv
// Frames SYNC/LEN/payload/CK byte streams into checked messages on a valid/ready port.
// Optional FRAMER_TS_EN: stamps each message with a free-running cycle count at SYNC.
module uart_msg_framer
    import uart_framer_pkg::*;
#(
    parameter int         MAX_PAYLOAD  = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 50000,
    parameter int         TS_W         = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx_valid,
    input  logic [7:0]                         rx_data,
    output logic                               msg_valid,
    input  logic                               msg_ready,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   msg_len,
    output logic [8*MAX_PAYLOAD-1:0]           msg_data,
    output logic [TS_W-1:0]                    msg_ts,
    output logic                               err_cksum,
    output logic                               err_len,
    output logic                               err_timeout,
    output logic [15:0]                        drop_cnt
);

    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

    framer_state_t    state;
    logic [7:0]       cksum;
    logic [LEN_W-1:0] idx;
    logic             timer_en;
    logic             expire;
    logic             sync_hit;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign timer_en = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CKSUM);
    assign sync_hit = (state == S_HUNT) && rx_valid && (rx_data == SYNC_BYTE);

    uart_frame_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (timer_en),
        .clear  (rx_valid),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HUNT;
            cksum       <= '0;
            idx         <= '0;
            msg_valid   <= 1'b0;
            msg_len     <= '0;
            msg_data    <= '0;
            err_cksum   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            err_cksum   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_HUNT: begin
                    if (sync_hit) begin
                        msg_data <= '0;
                        cksum    <= '0;
                        state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        if (len_ok(rx_data, MAX_PAYLOAD)) begin
                            msg_len <= LEN_W'(rx_data);
                            cksum   <= cksum ^ rx_data;
                            idx     <= '0;
                            state   <= S_PAYLOAD;
                        end else begin
                            err_len <= 1'b1;
                            state   <= S_HUNT;
                        end
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= S_HUNT;
                    end
                end
                S_PAYLOAD: begin
                    // SYNC_BYTE here is ordinary payload; no resynchronisation.
                    if (rx_valid) begin
                        for (int i = 0; i < MAX_PAYLOAD; i++) begin
                            if (idx == LEN_W'(i)) msg_data[8*i +: 8] <= rx_data;
                        end
                        cksum <= cksum ^ rx_data;
                        if (idx == msg_len - LEN_W'(1)) state <= S_CKSUM;
                        else                            idx   <= idx + LEN_W'(1);
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= S_HUNT;
                    end
                end
                S_CKSUM: begin
                    if (rx_valid) begin
                        if (rx_data == cksum) begin
                            msg_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else begin
                            err_cksum <= 1'b1;
                            state     <= S_HUNT;
                        end
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= S_HUNT;
                    end
                end
                S_HOLD: begin
                    if (rx_valid) drop_cnt <= sat_inc16(drop_cnt);
                    if (msg_ready) begin
                        msg_valid <= 1'b0;
                        state     <= S_HUNT;
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end

`ifdef FRAMER_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            msg_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (sync_hit) msg_ts <= ts_cnt;
        end
    end
`else
    assign msg_ts = '0;
`endif

endmodule

// File: tb/tb_uart_msg_framer.sv
// Directed plus randomized bench for uart_msg_framer against a frame-rule reference model.
`timescale 1ns/1ps
module tb_uart_msg_framer;

    localparam int MAXP = 16;
    localparam int TMO  = 20;
    localparam int LW   = $clog2(MAXP + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             msg_ready = 1'b0;
    logic             msg_valid;
    logic [LW-1:0]    msg_len;
    logic [8*MAXP-1:0] msg_data;
    logic [31:0]      msg_ts;
    logic             err_cksum, err_len, err_timeout;
    logic [15:0]      drop_cnt;
    logic [3:0]       status;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc;
    logic [31:0] drop_exp = 0;
    logic [7:0]  frm [$];

    uart_msg_framer #(
        .MAX_PAYLOAD (MAXP),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(TMO),
        .TS_W        (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_len    (msg_len),
        .msg_data   (msg_data),
        .msg_ts     (msg_ts),
        .err_cksum  (err_cksum),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    assign status = {msg_valid, err_cksum, err_len, err_timeout};

    // Reference cycle count since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    function automatic logic [31:0] ts_model(input logic [31:0] c);
`ifdef FRAMER_TS_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic build_frame(input int len, input bit corrupt);
        logic [7:0] ck, b;
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(8'(len));
        ck = 8'(len);
        for (int j = 0; j < len; j++) begin
            b = 8'($urandom);
            frm.push_back(b);
            ck ^= b;
        end
        if (corrupt) ck ^= 8'(1 << $urandom_range(0, 7));
        frm.push_back(ck);
    endtask

    // Sends frm with small random gaps; expectation derived from the frame rules alone.
    task automatic run_frame(input bit do_accept);
        int          n, len, hold;
        logic [7:0]  ck;
        logic [3:0]  fin;
        logic [31:0] ts_exp;
        logic [127:0] dexp;
        n   = frm.size();
        len = int'(frm[1]);
        ck  = frm[1];
        for (int i = 2; i < n - 1; i++) ck ^= frm[i];
        if (len == 0 || len > MAXP)  fin = 4'b0010;
        else if (frm[n-1] == ck)     fin = 4'b1000;
        else                         fin = 4'b0100;
        ts_exp = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) ts_exp = ts_model(cyc);
            send_byte(frm[i]);
            if (i < n - 1) begin
                chk("mid_frame_status", 128'(status), 128'(4'b0000));
                for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
            end else begin
                chk("frame_end_status", 128'(status), 128'(fin));
            end
        end
        if (fin == 4'b1000) begin
            dexp = '0;
            for (int i = 0; i < len; i++) dexp[8*i +: 8] = frm[2+i];
            chk("msg_len", 128'(msg_len), 128'(len));
            chk("msg_data", msg_data, dexp);
            chk("msg_ts", 128'(msg_ts), 128'(ts_exp));
            if (do_accept) begin
                hold = $urandom_range(0, 2);
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    chk("hold_valid", 128'(msg_valid), 128'(1'b1));
                    chk("hold_data", msg_data, dexp);
                end
                msg_ready = 1'b1;
                @(negedge clk);
                msg_ready = 1'b0;
                chk("after_accept", 128'(status), 128'(4'b0000));
            end
        end else begin
            @(negedge clk);
            chk("single_pulse", 128'(status), 128'(4'b0000));
        end
    endtask

    initial begin
        logic [127:0] held_data;
        logic [LW-1:0] held_len;
        logic [7:0] b;
        int kind, ng;

        #12;
        chk("reset_status", 128'(status), 128'(4'b0000));
        chk("reset_len", 128'(msg_len), 128'(0));
        chk("reset_data", msg_data, 128'(0));
        chk("reset_drop", 128'(drop_cnt), 128'(0));
        chk("reset_ts", 128'(msg_ts), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame
        frm = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
        run_frame(1'b1);

        // Bad checksum, then a good frame
        frm = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(1'b1);
        frm = '{8'hA5, 8'h02, 8'hA5, 8'h7E, 8'hD9};
        run_frame(1'b1);

        // Length errors, then hunt ignores a stray byte
        frm = '{8'hA5, 8'h11};
        run_frame(1'b1);
        frm = '{8'hA5, 8'h00};
        run_frame(1'b1);
        send_byte(8'h03);
        chk("hunt_ignore", 128'(status), 128'(4'b0000));
        build_frame(MAXP, 1'b0);
        run_frame(1'b1);
        build_frame(1, 1'b0);
        run_frame(1'b1);

        // Timeout mid-frame
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk);
            chk("pre_timeout", 128'(status), 128'(4'b0000));
        end
        @(negedge clk);
        chk("timeout_pulse", 128'(status), 128'(4'b0001));
        @(negedge clk);
        chk("timeout_single", 128'(status), 128'(4'b0000));
        for (int k = 0; k < TMO + 3; k++) @(negedge clk);
        chk("timeout_hunt_quiet", 128'(status), 128'(4'b0000));

        // Byte on the expiry cycle wins
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        for (int k = 1; k < TMO; k++) @(negedge clk);
        send_byte(8'h02);
        chk("expiry_byte_wins", 128'(status), 128'(4'b0000));
        send_byte(8'h03);
        send_byte(8'h03);
        chk("expiry_frame_ok", 128'(status), 128'(4'b1000));
        chk("expiry_frame_data", msg_data, 128'h030201);
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;

        // Backpressure: second frame dropped while holding the first
        build_frame(5, 1'b0);
        run_frame(1'b0);
        held_data = msg_data;
        held_len  = msg_len;
        frm = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
        foreach (frm[i]) begin
            send_byte(frm[i]);
            drop_exp++;
        end
        chk("bp_drop_cnt", 128'(drop_cnt), 128'(drop_exp));
        chk("bp_valid", 128'(status), 128'(4'b1000));
        chk("bp_data_stable", msg_data, held_data);
        chk("bp_len_stable", 128'(msg_len), 128'(held_len));
        msg_ready = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'hA5;
        @(negedge clk);
        msg_ready = 1'b0;
        rx_valid  = 1'b0;
        drop_exp++;
        chk("handshake_drop", 128'(drop_cnt), 128'(drop_exp));
        chk("handshake_release", 128'(status), 128'(4'b0000));
        frm = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
        run_frame(1'b1);

        // Randomized frames with garbage between them
        for (int f = 0; f < 40; f++) begin
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                do b = 8'($urandom); while (b == 8'hA5);
                send_byte(b);
                chk("garbage_ignored", 128'(status), 128'(4'b0000));
            end
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                frm.delete();
                frm.push_back(8'hA5);
                if ($urandom_range(0, 1) == 1) frm.push_back(8'h00);
                else frm.push_back(8'($urandom_range(MAXP + 1, 255)));
            end else begin
                build_frame($urandom_range(1, MAXP), kind == 1);
            end
            run_frame(1'b1);
        end
        chk("final_drop_cnt", 128'(drop_cnt), 128'(drop_exp));

        // Reset mid-payload
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        chk("midreset_status", 128'(status), 128'(4'b0000));
        chk("midreset_data", msg_data, 128'(0));
        chk("midreset_len", 128'(msg_len), 128'(0));
        chk("midreset_drop", 128'(drop_cnt), 128'(0));
        chk("midreset_ts", 128'(msg_ts), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drop_exp = 0;
        @(negedge clk);
        @(negedge clk);
        build_frame(4, 1'b0);
        run_frame(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
